tdm_demux8x16: RTL and testbench

- Receiver end of the team's 8-slot time-division word link: the transmitter sends one 16-bit word per slot, slot 0 flagged by start-of-frame.
- Block rebuilds the 8 parallel words and presents them on eight registered 16-bit outputs.
- Outputs update atomically, only when a complete frame has arrived; partial frames never reach them.
- Sits between the serial word link and any consumer of the eight channels (register banks, ALU operand select).

---
 rtl/tdm_pkg.sv | 20 ++
 rtl/tdm_slot_reg.sv | 31 +++
 rtl/tdm_demux8x16.sv | 154 +++++++++++++++
 tb/tb_tdm_demux8x16.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared types and constants for the 8-slot TDM word-link receiver.
package tdm_pkg;

  localparam int SLOTS     = 8;
  localparam int SLOT_W    = 3;
  localparam int WIDTH_DEF = 16;

  localparam logic [SLOT_W-1:0] LAST_SLOT = 3'd7;

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  function automatic logic [SLOTS-1:0] slot_onehot(input logic [SLOT_W-1:0] idx);
    slot_onehot      = '0;
    slot_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/tdm_slot_reg.sv
// Shadow bank of eight slot words; a frame is assembled here before it is committed.
module tdm_slot_reg
  import tdm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [SLOT_W-1:0]            wr_idx,
  input  logic [WIDTH-1:0]             wr_data,
  output logic [SLOTS-1:0][WIDTH-1:0]  words
);

  logic [SLOTS-1:0] sel;

  assign sel = wr_en ? slot_onehot(wr_idx) : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      words <= '0;
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        if (sel[i]) begin
          words[i] <= wr_data;
        end
      end
    end
  end

endmodule

// File: rtl/tdm_demux8x16.sv
// Rebuilds 8 TDM slot words into eight registered outputs, committed atomically per frame.
// Optional mid-frame idle abort is enabled by defining TDM_DEMUX_TIMEOUT_EN.
module tdm_demux8x16
  import tdm_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [WIDTH-1:0]  in_data,
  output logic [WIDTH-1:0]  a,
  output logic [WIDTH-1:0]  b,
  output logic [WIDTH-1:0]  c,
  output logic [WIDTH-1:0]  d,
  output logic [WIDTH-1:0]  e,
  output logic [WIDTH-1:0]  f,
  output logic [WIDTH-1:0]  g,
  output logic [WIDTH-1:0]  h,
  output logic              frame_valid,
  output logic              frame_err,
  output logic [SLOT_W-1:0] slot
);

  state_t                       state_q, state_d;
  logic [SLOT_W-1:0]            slot_q, slot_d;
  logic                         wr_en;
  logic [SLOT_W-1:0]            wr_idx;
  logic                         commit;
  logic                         err_d;
  logic                         idle_hit;
  logic                         fv_q, fe_q;
  logic [SLOTS-1:0][WIDTH-1:0]  shadow;
  logic [SLOTS-1:0][WIDTH-1:0]  commit_words;
  logic [SLOTS-1:0][WIDTH-1:0]  out_q;

`ifdef TDM_DEMUX_TIMEOUT_EN
  localparam int IdleW = $clog2(TIMEOUT + 1);

  logic [IdleW-1:0] idle_q, idle_d;

  // idle_hit marks the TIMEOUT-th consecutive idle cycle inside a frame
  assign idle_hit = (idle_q == IdleW'(TIMEOUT - 1));

  always_comb begin
    idle_d = '0;
    if (state_q == COLLECT && !in_valid && !idle_hit) begin
      idle_d = idle_q + IdleW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  assign idle_hit = 1'b0;
`endif

  tdm_slot_reg #(.WIDTH(WIDTH)) u_shadow (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (in_data),
    .words   (shadow)
  );

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    wr_en   = 1'b0;
    wr_idx  = slot_q;
    commit  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_sof) begin
          wr_en   = 1'b1;
          wr_idx  = '0;
          slot_d  = SLOT_W'(1);
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (in_sof) begin
            // early SOF restarts the frame; the stale partial words get overwritten
            wr_idx = '0;
            slot_d = SLOT_W'(1);
            err_d  = 1'b1;
          end else if (slot_q == LAST_SLOT) begin
            commit  = 1'b1;
            slot_d  = '0;
            state_d = IDLE;
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end else if (idle_hit) begin
          err_d   = 1'b1;
          slot_d  = '0;
          state_d = IDLE;
        end
      end
      default: begin
        slot_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // slot 7 bypasses the bank so the whole frame lands on the accepting edge
  always_comb begin
    commit_words            = shadow;
    commit_words[LAST_SLOT] = in_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      slot_q  <= '0;
      fv_q    <= 1'b0;
      fe_q    <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      fv_q    <= commit;
      fe_q    <= err_d;
      if (commit) begin
        out_q <= commit_words;
      end
    end
  end

  assign a           = out_q[0];
  assign b           = out_q[1];
  assign c           = out_q[2];
  assign d           = out_q[3];
  assign e           = out_q[4];
  assign f           = out_q[5];
  assign g           = out_q[6];
  assign h           = out_q[7];
  assign frame_valid = fv_q;
  assign frame_err   = fe_q;
  assign slot        = slot_q;

endmodule

// File: tb/tb_tdm_demux8x16.sv
// Self-checking bench for tdm_demux8x16: directed vector tables, hand sequences and a random run against a frame-queue model.
module tb_tdm_demux8x16;

  localparam int W   = 16;
  localparam int TMO = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_sof = 1'b0;
  logic [W-1:0] in_data = '0;
  logic [W-1:0] a, b, c, d, e, f, g, h;
  logic         frame_valid, frame_err;
  logic [2:0]   slot;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [W-1:0] mFrame[$];
  logic [W-1:0] mOut[8];
  bit           mFv, mFe;
  int           mIdle;

  typedef struct {
    bit           v;
    bit           s;
    logic [W-1:0] d;
    bit           ev;
    bit           ee;
    logic [2:0]   es;
  } vec_t;

  vec_t tbl[$];

  tdm_demux8x16 #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_sof      (in_sof),
    .in_data     (in_data),
    .a           (a),
    .b           (b),
    .c           (c),
    .d           (d),
    .e           (e),
    .f           (f),
    .g           (g),
    .h           (h),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .slot        (slot)
  );

  always #5 clock = ~clock;

  task automatic compare(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Reference model: a frame is just the ordered list of words accepted since the last SOF
  function automatic void modelReset();
    mFrame.delete();
    for (int i = 0; i < 8; i++) mOut[i] = '0;
    mFv   = 1'b0;
    mFe   = 1'b0;
    mIdle = 0;
  endfunction

  function automatic void modelStep(input bit v, input bit s, input logic [W-1:0] dd);
    mFv = 1'b0;
    mFe = 1'b0;
    if (v) begin
      mIdle = 0;
      if (s) begin
        if (mFrame.size() != 0) mFe = 1'b1;
        mFrame.delete();
        mFrame.push_back(dd);
      end else if (mFrame.size() != 0) begin
        mFrame.push_back(dd);
        if (mFrame.size() == 8) begin
          for (int i = 0; i < 8; i++) mOut[i] = mFrame[i];
          mFv = 1'b1;
          mFrame.delete();
        end
      end
    end else if (mFrame.size() != 0) begin
      mIdle++;
`ifdef TDM_DEMUX_TIMEOUT_EN
      if (mIdle == TMO) begin
        mFe = 1'b1;
        mFrame.delete();
        mIdle = 0;
      end
`endif
    end
  endfunction

  task automatic checkOutput(input string tag);
    logic [W-1:0] act[8];
    act = '{a, b, c, d, e, f, g, h};
    compare({tag, " frame_valid"}, W'(frame_valid), W'(mFv));
    compare({tag, " frame_err"}, W'(frame_err), W'(mFe));
    compare({tag, " slot"}, W'(slot), W'(mFrame.size()));
    for (int i = 0; i < 8; i++) begin
      compare($sformatf("%s out[%0d]", tag, i), act[i], mOut[i]);
    end
  endtask

  task automatic applyStimulus(input bit v, input bit s, input logic [W-1:0] dd, input string tag);
    @(negedge clock);
    reset    = 1'b0;
    in_valid = v;
    in_sof   = s;
    in_data  = dd;
    @(posedge clock);
    #1;
    modelStep(v, s, dd);
    checkOutput(tag);
  endtask

  task automatic resetDut(input bit v, input bit s, input logic [W-1:0] dd);
    @(negedge clock);
    reset    = 1'b1;
    in_valid = v;
    in_sof   = s;
    in_data  = dd;
    @(posedge clock);
    #1;
    modelReset();
    checkOutput("reset");
  endtask

  task automatic runTable(input string tag);
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].v, tbl[i].s, tbl[i].d, $sformatf("%s[%0d]", tag, i));
      compare($sformatf("%s[%0d] tbl frame_valid", tag, i), W'(frame_valid), W'(tbl[i].ev));
      compare($sformatf("%s[%0d] tbl frame_err", tag, i), W'(frame_err), W'(tbl[i].ee));
      compare($sformatf("%s[%0d] tbl slot", tag, i), W'(slot), W'(tbl[i].es));
    end
    tbl.delete();
  endtask

  task automatic checkBank(input string tag, input logic [W-1:0] base);
    logic [W-1:0] act[8];
    act = '{a, b, c, d, e, f, g, h};
    for (int i = 0; i < 8; i++) begin
      compare($sformatf("%s bank[%0d]", tag, i), act[i], base + W'(i));
    end
  endtask

  initial begin
    modelReset();
    resetDut(1'b0, 1'b0, '0);
    compare("reset a", a, 16'h0000);
    compare("reset slot", W'(slot), 16'h0000);

    // Full back-to-back frame
    for (int i = 0; i < 8; i++)
      tbl.push_back('{1'b1, i == 0, 16'h1000 + W'(i), i == 7, 1'b0, 3'((i + 1) % 8)});
    tbl.push_back('{1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 3'd0});
    runTable("full");
    checkBank("full", 16'h1000);

    // Same frame shape with two idle cycles after each word
    for (int i = 0; i < 8; i++) begin
      tbl.push_back('{1'b1, i == 0, 16'h3000 + W'(i), i == 7, 1'b0, 3'((i + 1) % 8)});
      if (i < 7) begin
        tbl.push_back('{1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 3'(i + 1)});
        tbl.push_back('{1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 3'(i + 1)});
      end
    end
    runTable("gaps");
    checkBank("gaps", 16'h3000);

    // Early SOF discards the 0xAAAA partial frame
    tbl.push_back('{1'b1, 1'b1, 16'hAAAA, 1'b0, 1'b0, 3'd1});
    for (int i = 1; i < 4; i++)
      tbl.push_back('{1'b1, 1'b0, 16'hAAAA + W'(i), 1'b0, 1'b0, 3'(i + 1)});
    for (int i = 0; i < 8; i++)
      tbl.push_back('{1'b1, i == 0, 16'h2000 + W'(i), i == 7, i == 0, 3'((i + 1) % 8)});
    runTable("early_sof");
    checkBank("early_sof", 16'h2000);

    // Non-SOF words while idle are dropped
    for (int i = 0; i < 3; i++)
      tbl.push_back('{1'b1, 1'b0, 16'hDEAD, 1'b0, 1'b0, 3'd0});
    runTable("idle_drop");
    checkBank("idle_drop", 16'h2000);

    // Reset mid-frame, with a word on the reset edge that must be ignored
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, i == 0, 16'h5000 + W'(i), "pre_reset");
    resetDut(1'b1, 1'b0, 16'h5005);
    compare("midreset slot", W'(slot), 16'h0000);
    compare("midreset frame_err", W'(frame_err), 16'h0000);
    compare("midreset h", h, 16'h0000);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, i == 0, 16'h4000 + W'(i), "post_reset");
    compare("post_reset frame_valid", W'(frame_valid), 16'h0001);
    checkBank("post_reset", 16'h4000);

    // SOF + 2 words, then TMO idle cycles
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, i == 0, 16'h6000 + W'(i), "tmo_words");
    for (int i = 0; i < TMO; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0, "tmo_idle");
      if (i == TMO - 2) compare("tmo early frame_err", W'(frame_err), 16'h0000);
    end
`ifdef TDM_DEMUX_TIMEOUT_EN
    compare("tmo frame_err", W'(frame_err), 16'h0001);
    compare("tmo slot", W'(slot), 16'h0000);
`else
    compare("tmo frame_err", W'(frame_err), 16'h0000);
    compare("tmo slot", W'(slot), 16'h0003);
`endif
    checkBank("tmo", 16'h4000);

    // Randomized traffic against the model, with occasional long gaps and resets
    resetDut(1'b0, 1'b0, '0);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        resetDut($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, W'($urandom));
      end else if ($urandom_range(0, 99) == 0) begin
        for (int k = 0; k < TMO + 2; k++) applyStimulus(1'b0, 1'b0, W'($urandom), "rand_gap");
      end else begin
        applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, W'($urandom), "rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
